// File: rtl/bist_signature_checker_pkg.sv
// Shared types and constants for the BIST signature checker (package bist_pkg).
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } bist_state_t;

  localparam int BIST_SIG_W = 8;
  localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_DEFAULT = 8'h00;

endpackage

// File: rtl/bist_signature_checker.sv
// Sequences one BIST session (TEST_LEN run cycles, FLUSH_CYC settle cycles), then captures and judges the MISR signature.
// Optional diagnostics (sig_diff, fail_cnt) are built when BIST_CHECK_DIAG_EN is defined.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int                SIG_W     = BIST_SIG_W,
  parameter int                TEST_LEN  = 16,
  parameter int                FLUSH_CYC = 2,
  parameter logic [SIG_W-1:0]  GOLDEN    = SIG_W'(BIST_GOLDEN_DEFAULT),
  parameter int                CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [SIG_W-1:0] sig_in,
  output logic             test_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_captured
`ifdef BIST_CHECK_DIAG_EN
  ,
  output logic [SIG_W-1:0] sig_diff,
  output logic [3:0]       fail_cnt
`endif
);

  if (TEST_LEN < 1 || FLUSH_CYC < 1) begin : g_bad_params
    $error("bist_signature_checker: TEST_LEN and FLUSH_CYC must both be >= 1");
  end

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TEST_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

  bist_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             test_en_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [SIG_W-1:0] sig_cap_nxt;
`ifdef BIST_CHECK_DIAG_EN
  logic [SIG_W-1:0] sig_diff_nxt;
  logic [3:0]       fail_cnt_nxt;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (cnt == RUN_LAST) state_nxt = FLUSH;
      FLUSH:      if (cnt == FLUSH_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Computes the next value of every registered output; the register below only applies reset.
  always_comb begin
    cnt_nxt     = cnt;
    test_en_nxt = test_en;
    busy_nxt    = busy;
    done_nxt    = done;
    pass_nxt    = pass;
    sig_cap_nxt = sig_captured;
`ifdef BIST_CHECK_DIAG_EN
    sig_diff_nxt = sig_diff;
    fail_cnt_nxt = fail_cnt;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          cnt_nxt     = '0;
          test_en_nxt = 1'b1;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          pass_nxt    = 1'b0;
        end
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          cnt_nxt     = '0;
          test_en_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == FLUSH_LAST) begin
          sig_cap_nxt = sig_in;
          pass_nxt    = (sig_in == GOLDEN);
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
`ifdef BIST_CHECK_DIAG_EN
          sig_diff_nxt = sig_in ^ GOLDEN;
          if (sig_in != GOLDEN && fail_cnt != 4'hF) fail_cnt_nxt = fail_cnt + 4'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      test_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      sig_captured <= '0;
`ifdef BIST_CHECK_DIAG_EN
      sig_diff     <= '0;
      fail_cnt     <= '0;
`endif
    end else begin
      cnt          <= cnt_nxt;
      test_en      <= test_en_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pass         <= pass_nxt;
      sig_captured <= sig_cap_nxt;
`ifdef BIST_CHECK_DIAG_EN
      sig_diff     <= sig_diff_nxt;
      fail_cnt     <= fail_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Scoreboard bench for bist_signature_checker: driver pushes expected session results, monitor checks them on done.
module tb_bist_signature_checker;

  localparam logic [7:0] G = 8'hA5;
  localparam int TL = 16;
  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic [7:0] sig_in, sig_in1;
  logic       test_en, busy, done, pass;
  logic [7:0] sig_captured;
  logic       test_en1, busy1, done1, pass1;
  logic [7:0] sig_captured1;
`ifdef BIST_CHECK_DIAG_EN
  logic [7:0] sig_diff, sig_diff1;
  logic [3:0] fail_cnt, fail_cnt1;
`endif

  bist_signature_checker #(.SIG_W(8), .TEST_LEN(TL), .FLUSH_CYC(FC), .GOLDEN(G), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .start(start), .sig_in(sig_in),
    .test_en(test_en), .busy(busy), .done(done), .pass(pass), .sig_captured(sig_captured)
`ifdef BIST_CHECK_DIAG_EN
    , .sig_diff(sig_diff), .fail_cnt(fail_cnt)
`endif
  );

  bist_signature_checker #(.SIG_W(8), .TEST_LEN(1), .FLUSH_CYC(1), .GOLDEN(G), .CNT_W(8)) dut1 (
    .CLK(clk), .RST(rst), .start(start1), .sig_in(sig_in1),
    .test_en(test_en1), .busy(busy1), .done(done1), .pass(pass1), .sig_captured(sig_captured1)
`ifdef BIST_CHECK_DIAG_EN
    , .sig_diff(sig_diff1), .fail_cnt(fail_cnt1)
`endif
  );

  typedef struct {
    int         done_cyc;
    logic [7:0] sig;
    logic       pass;
    logic [7:0] diff;
    logic [3:0] fcnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rand_bad();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == G) v = v ^ 8'h01;
    return v;
  endfunction

  // One session on the main DUT; sig_in carries v only on the cycle the capture edge samples.
  task automatic session(input logic [7:0] v, input int hold);
    logic [7:0] junk;
    exp_t e;
    int c0;
    junk = v ^ 8'($urandom_range(1, 255));
    @(negedge clk);
    start  = 1'b1;
    sig_in = junk;
    c0 = cyc + 1;
    if (v != G && model_fails < 15) model_fails++;
    e.done_cyc = c0 + TL + FC;
    e.sig  = v;
    e.pass = (v == G);
    e.diff = v ^ G;
    e.fcnt = 4'(model_fails);
    q.push_back(e);
    for (int k = 1; k <= TL + FC; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("start_test_en", test_en, 1);
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_pass_clr", pass, 0);
      end
      start  = (k < hold);
      sig_in = (k == TL + FC) ? v : junk;
    end
    @(negedge clk);
    start  = 1'b0;
    sig_in = junk;
  endtask

  // Monitor: on each done rising edge pop one expected result.
  initial begin
    logic done_q;
    int te_cnt;
    exp_t e;
    done_q = 1'b0;
    te_cnt = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_q) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_latency", cyc, e.done_cyc);
          check("pass", pass, e.pass);
          check("sig_captured", sig_captured, e.sig);
          check("test_en_cycles", te_cnt, TL);
          check("busy_at_done", busy, 0);
`ifdef BIST_CHECK_DIAG_EN
          check("sig_diff", sig_diff, e.diff);
          check("fail_cnt", fail_cnt, e.fcnt);
`endif
        end
      end
      done_q = (done === 1'b1);
      if (busy !== 1'b1) te_cnt = 0;
      else if (test_en === 1'b1) te_cnt++;
    end
  end

  initial begin
    logic [7:0] v, junk;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; sig_in = 8'h00; sig_in1 = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b1; start1 = 1'b1;
    @(negedge clk);
    check("rst_test_en", test_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig_captured", sig_captured, 0);
    check("rst_test_en1", test_en1, 0);
    rst = 1'b0; start = 1'b0; start1 = 1'b0;

    session(G, 1);
    session(8'hA4, 1);

    // Abort a session at cnt=5 with a reset pulse.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_test_en", test_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_fails = 0;
    check("abort_test_en", test_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_sig_captured", sig_captured, 0);
`ifdef BIST_CHECK_DIAG_EN
    check("abort_fail_cnt", fail_cnt, 0);
    check("abort_sig_diff", sig_diff, 0);
`endif
    repeat (TL + FC + 4) @(negedge clk);
    check("abort_no_done", done, 0);

    session(8'($urandom_range(0, 255)), 10);

    for (int i = 0; i < 20; i++) begin
      v = (i % 5 == 4) ? G : rand_bad();
      session(v, 1);
    end

    // Minimal session length on the second instance.
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? G : rand_bad();
      junk = v ^ 8'($urandom_range(1, 255));
      @(negedge clk);
      start1 = 1'b1; sig_in1 = junk;
      @(negedge clk);
      start1 = 1'b0;
      check("edge_test_en_on", test_en1, 1);
      check("edge_done_early", done1, 0);
      @(negedge clk);
      check("edge_test_en_off", test_en1, 0);
      check("edge_done_mid", done1, 0);
      sig_in1 = v;
      @(negedge clk);
      sig_in1 = junk;
      check("edge_done", done1, 1);
      check("edge_pass", pass1, (v == G));
      check("edge_sig_captured", sig_captured1, v);
      check("edge_busy", busy1, 0);
    end

    repeat (3) @(negedge clk);
    check("pending_sessions", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
